// File: rtl/recovery_sequencer.sv
// Multi-source flush arbiter and recovery sequencer (IDLE/START/FLUSH/ROLLBACK) with wrap-aware ROB age compare.
// Optional performance counters are enabled by defining RECOVERY_PERF_CNT_EN.
module recovery_sequencer #(
    parameter int unsigned NUM_SRC   = 3,
    parameter int unsigned ROB_TAG_W = 6
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_SRC-1:0]             src_valid,
    input  logic [NUM_SRC*ROB_TAG_W-1:0]   src_rob_tag,
    input  logic [ROB_TAG_W-1:0]           rob_head_tag,
    input  logic                           rob_recovery_finished,
    output logic [NUM_SRC-1:0]             src_ack,
    output logic                           flush_bcast_valid,
    output logic [ROB_TAG_W-1:0]           flush_bcast_tag,
    output logic                           recovery_start,
    output logic                           recovery_flush,
    output logic                           recovery_rollback,
    output logic                           recovery_procedure,
    output logic                           recovery_stall
`ifdef RECOVERY_PERF_CNT_EN
    ,
    output logic [31:0]                    perf_recovery_cnt,
    output logic [31:0]                    perf_recovery_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        FLUSH,
        ROLLBACK
    } state_e;

    state_e                 state_q, state_d;
    logic [ROB_TAG_W-1:0]   tag_q, tag_d;
    logic [NUM_SRC-1:0]     ack_q, ack_d;
    logic                   start_q, start_d;
    logic                   flush_q, flush_d;
    logic                   rollback_q, rollback_d;
    logic                   proc_q, proc_d;
    logic [ROB_TAG_W-1:0]   bcast_tag_q, bcast_tag_d;

    logic [ROB_TAG_W-1:0]   src_age [NUM_SRC];
    logic                   sel_found;
    logic [ROB_TAG_W-1:0]   sel_age;
    logic [ROB_TAG_W-1:0]   sel_tag;
    logic [NUM_SRC-1:0]     sel_oh;
    logic [ROB_TAG_W-1:0]   cur_age;
    logic                   preempt;

    // Age is the modular distance from the ROB head, so wrap-around needs no special case.
    always_comb begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            src_age[i] = src_rob_tag[i*ROB_TAG_W +: ROB_TAG_W] - rob_head_tag;
        end
    end

    // Strict less-than keeps the lowest index on an age tie.
    always_comb begin
        sel_found = 1'b0;
        sel_age   = '1;
        sel_tag   = '0;
        sel_oh    = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (src_valid[i] && (!sel_found || (src_age[i] < sel_age))) begin
                sel_found = 1'b1;
                sel_age   = src_age[i];
                sel_tag   = src_rob_tag[i*ROB_TAG_W +: ROB_TAG_W];
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
            end
        end
    end

    assign cur_age = tag_q - rob_head_tag;
    assign preempt = sel_found && (sel_age < cur_age);

    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        ack_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d = START;
                    tag_d   = sel_tag;
                    ack_d   = sel_oh;
                end
            end
            START, FLUSH, ROLLBACK: begin
                // An older offender restarts the sequence and outranks a pending rollback exit.
                if (preempt) begin
                    state_d = START;
                    tag_d   = sel_tag;
                    ack_d   = sel_oh;
                end else if (state_q == START) begin
                    state_d = FLUSH;
                end else if (state_q == FLUSH) begin
                    state_d = ROLLBACK;
                end else if (rob_recovery_finished) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        start_d     = (state_d == START);
        flush_d     = (state_d == FLUSH);
        rollback_d  = (state_d == ROLLBACK);
        proc_d      = (state_d != IDLE);
        bcast_tag_d = (state_d == FLUSH) ? tag_d : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tag_q       <= '0;
            ack_q       <= '0;
            start_q     <= 1'b0;
            flush_q     <= 1'b0;
            rollback_q  <= 1'b0;
            proc_q      <= 1'b0;
            bcast_tag_q <= '0;
        end else begin
            state_q     <= state_d;
            tag_q       <= tag_d;
            ack_q       <= ack_d;
            start_q     <= start_d;
            flush_q     <= flush_d;
            rollback_q  <= rollback_d;
            proc_q      <= proc_d;
            bcast_tag_q <= bcast_tag_d;
        end
    end

    assign src_ack            = ack_q;
    assign recovery_start     = start_q;
    assign recovery_flush     = flush_q;
    assign flush_bcast_valid  = flush_q;
    assign flush_bcast_tag    = bcast_tag_q;
    assign recovery_rollback  = rollback_q;
    assign recovery_procedure = proc_q;
    assign recovery_stall     = proc_q;

`ifdef RECOVERY_PERF_CNT_EN
    logic [31:0] perf_cnt_q, perf_cyc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt_q <= '0;
            perf_cyc_q <= '0;
        end else begin
            if (start_q && (perf_cnt_q != '1)) begin
                perf_cnt_q <= perf_cnt_q + 32'd1;
            end
            if (proc_q && (perf_cyc_q != '1)) begin
                perf_cyc_q <= perf_cyc_q + 32'd1;
            end
        end
    end

    assign perf_recovery_cnt    = perf_cnt_q;
    assign perf_recovery_cycles = perf_cyc_q;
`endif

endmodule

// File: doc/recovery_sequencer.md
Name: recovery_sequencer

Overview:
- Parametrised recovery controller that arbitrates NUM_SRC flush sources, e.g. branch mispredict, load/store violation and store-set violation.
- Picks the oldest offending instruction by ROB-tag age relative to the ROB head.
- Drives the start/flush/rollback/procedure/stall sequence and the flush-tag broadcast consumed by the RNDS, IQ, EXE, LSU and ROB stages.
- Sits beside the pipeline controller; adds multi-source arbitration, wrap-aware age compare and preemption by an older flush.

Parameters:
NUM_SRC, 3, number of flush request sources (1..8)
ROB_TAG_W, 6, ROB tag width; tags compare modulo 2^ROB_TAG_W

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
src_valid  in  NUM_SRC  per-source flush request, sampled every cycle (pulse allowed)
src_rob_tag  in  NUM_SRC*ROB_TAG_W  per-source offending tag; source i at bits [i*ROB_TAG_W +: ROB_TAG_W]
rob_head_tag  in  ROB_TAG_W  current ROB head (oldest in-flight) tag
rob_recovery_finished  in  1  ROB rollback complete pulse
src_ack  out  NUM_SRC  one-hot, 1-cycle pulse: request accepted
flush_bcast_valid  out  1  flush broadcast valid
flush_bcast_tag  out  ROB_TAG_W  tag of the oldest instruction being flushed
recovery_start  out  1  1-cycle pulse opening a recovery
recovery_flush  out  1  1-cycle pulse; younger-than-tag entries are invalidated
recovery_rollback  out  1  high while waiting for ROB rollback
recovery_procedure  out  1  high in any non-IDLE state
recovery_stall  out  1  front-end and rename stall; high in any non-IDLE state

Behaviour:
- The interface is fixed at one clock, clk, with reset rst_n asynchronous and active-low. All outputs are registered and reset to 0; the FSM resets to IDLE and the captured tag to 0.
- Age of a tag = (tag - rob_head_tag) mod 2^ROB_TAG_W, unsigned ROB_TAG_W-bit subtraction. Smaller age = older.
- Selection: among asserted src_valid, take minimum age. On an age tie, the lowest source index wins.
- FSM states: IDLE, START, FLUSH, ROLLBACK.
- IDLE:
  - Any src_valid in cycle T moves the FSM to START in T+1.
  - In T+1: recovery_start=1, src_ack[winner]=1, captured tag = winner's tag.
  - Losing same-cycle requests are dropped with no ack; they are younger and are squashed anyway.
- START -> FLUSH after exactly 1 cycle. In FLUSH: recovery_flush=1, flush_bcast_valid=1, flush_bcast_tag=captured tag.
- FLUSH -> ROLLBACK after exactly 1 cycle. recovery_rollback stays high until rob_recovery_finished.
- ROLLBACK with rob_recovery_finished=1 -> IDLE in the next cycle, and all outputs drop.
- rob_recovery_finished is ignored in IDLE, START and FLUSH.
- Preemption in START, FLUSH or ROLLBACK:
  - A src_valid whose age is strictly less than the captured tag's age (using the current rob_head_tag) restarts the sequence.
  - Next cycle: START, new captured tag, src_ack pulse for that source. Any partial ROLLBACK is abandoned.
  - Equal or younger requests are dropped, with no ack.
- Minimum sequence length is 3 cycles: start, flush, at least 1 rollback cycle.
- A new request is accepted in the same cycle the FSM returns to IDLE. A request arriving in the ROLLBACK-exit cycle is evaluated as a preemption candidate only.
- Mid-operation rst_n assertion: immediate return to IDLE with all outputs 0. No broadcast is replayed after reset.

Optional Feature:
RECOVERY_PERF_CNT_EN:
- When defined, adds outputs perf_recovery_cnt[31:0] and perf_recovery_cycles[31:0], both reset to 0.
- perf_recovery_cnt increments on each recovery_start, preemptions included.
- perf_recovery_cycles increments every cycle recovery_procedure=1.
- Both counters saturate at 2^32-1.
- When undefined, neither port nor counter exists.

Test Plan:
- Oldest-wins: ROB_TAG_W=6, head=10, src0 tag 20 and src1 tag 12 in the same cycle -> next cycle src_ack=3'b010, recovery_start=1. Following cycle flush_bcast_tag=12, recovery_flush=1.
- Wrap-around: head=60, src0 tag 2 (age 6), src2 tag 63 (age 3) -> src_ack=3'b100, flush_bcast_tag=63.
- Preempt older: in ROLLBACK with tag 30, head 10, src1 tag 25 -> next cycle START and src_ack=3'b010; then flush_bcast_tag=25 and rollback restarts.
- Drop younger and tie: in ROLLBACK with tag 30, src0 tag 40 -> no ack, state unchanged. Two sources with tag 30 in IDLE -> lower index acked.
- Rollback wait: hold rob_recovery_finished=0 for 5 ROLLBACK cycles -> recovery_rollback stays 1. Pulse finished -> next cycle all outputs 0, state IDLE. finished pulsed during FLUSH -> ignored.
- Reset mid-recovery: drop rst_n during FLUSH -> outputs 0 immediately. Release rst_n with no requests -> stays IDLE. With RECOVERY_PERF_CNT_EN defined, counters read 0 after reset.
